oddr_serializer: RTL and testbench

Parametrised multi-lane DDR output serializer for iCE40 designs. Accepts a parallel word per lane and shifts it out as DDR bit pairs over RATIO clocks. Also generates a forwarded DDR clock lane and a registered output enable. Its outputs feed one DDR output-register pin cell per lane (first-half bit, second-half bit); the block sits between a Wishbone-side controller (flash, HyperRAM, LCD) and the pads.

---
 rtl/oddr_serializer.sv | 167 ++++++++++++++++
 tb/tb_oddr_serializer.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oddr_serializer.sv
// Multi-lane DDR output serializer: one parallel word per lane goes out as
// first-half/second-half bit pairs over RATIO clocks, with a forwarded clock and pad enable.
module oddr_serializer #(
    parameter int   NLANES    = 4,
    parameter int   RATIO     = 4,
    parameter logic IDLE      = 1'b1,
    parameter int   MSB_FIRST = 1
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_stb,
    input  logic [NLANES*2*RATIO-1:0]  i_data,
    output logic                       o_busy,
    output logic [2*NLANES-1:0]        o_ddr,
    output logic [1:0]                 o_ck_ddr,
    output logic                       o_oe,
    output logic                       o_done
);

    localparam int SW = 2 * RATIO;
    localparam int DW = NLANES * SW;
    localparam int CW = (RATIO > 1) ? $clog2(RATIO) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(RATIO - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    localparam logic [1:0] CK_ON  = 2'b10;
    localparam logic [1:0] CK_OFF = 2'b00;

    localparam logic [2*NLANES-1:0] DDR_IDLE = {(2*NLANES){IDLE}};

    logic [0:0]          state_q, state_d;
    logic [CW-1:0]       cnt_q,   cnt_d;
    logic [DW-1:0]       sr_q,    sr_d;
    logic [2*NLANES-1:0] ddr_q,   ddr_d;
    logic [1:0]          ck_q,    ck_d;
    logic                oe_q,    oe_d;
    logic                done_q,  done_d;

    logic                busy_s;
    logic                load_s;
    logic                step_s;

    // The pair that leaves first from each lane slice of a word.
    function automatic logic [2*NLANES-1:0] beat_of(input logic [DW-1:0] w);
        logic [2*NLANES-1:0] b;
        b = '0;
        for (int k = 0; k < NLANES; k++) begin
            if (MSB_FIRST != 0) begin
                b[2*k+1] = w[k*SW+SW-1];
                b[2*k]   = w[k*SW+SW-2];
            end else begin
                b[2*k+1] = w[k*SW];
                b[2*k]   = w[k*SW+1];
            end
        end
        return b;
    endfunction

    // Drop the pair just sent from every lane slice, keeping lanes independent.
    function automatic logic [DW-1:0] shift_of(input logic [DW-1:0] w);
        logic [DW-1:0] r;
        logic [SW-1:0] s;
        r = '0;
        for (int k = 0; k < NLANES; k++) begin
            s = w[k*SW +: SW];
            if (MSB_FIRST != 0) begin
                s = s << 2'd2;
            end else begin
                s = s >> 2'd2;
            end
            r[k*SW +: SW] = s;
        end
        return r;
    endfunction

    assign busy_s = (state_q == ST_SHIFT) && (cnt_q != '0);

    // Decide whether this edge loads a new word, advances a beat, or goes idle.
    always_comb begin
        load_s = 1'b0;
        step_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                load_s = i_stb;
            end
            ST_SHIFT: begin
                if (cnt_q != '0) begin
                    step_s = 1'b1;
                end else begin
                    load_s = i_stb;
                end
            end
            default: begin
                load_s = 1'b0;
                step_s = 1'b0;
            end
        endcase
    end

    // Next-state values for the shifter and its registered outputs.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        ddr_d   = ddr_q;
        ck_d    = ck_q;
        oe_d    = oe_q;
        done_d  = 1'b0;
        if (load_s) begin
            state_d = ST_SHIFT;
            cnt_d   = CNT_LAST;
            ddr_d   = beat_of(i_data);
            sr_d    = shift_of(i_data);
            ck_d    = CK_ON;
            oe_d    = 1'b1;
            done_d  = (CNT_LAST == '0);
        end else if (step_s) begin
            state_d = ST_SHIFT;
            cnt_d   = cnt_q - CNT_ONE;
            ddr_d   = beat_of(sr_q);
            sr_d    = shift_of(sr_q);
            ck_d    = CK_ON;
            oe_d    = 1'b1;
            done_d  = (cnt_q == CNT_ONE);
        end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            sr_d    = '0;
            ddr_d   = DDR_IDLE;
            ck_d    = CK_OFF;
            oe_d    = 1'b0;
            done_d  = 1'b0;
        end
    end

    // State and output registers; reset abandons any word in flight.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
            ddr_q   <= DDR_IDLE;
            ck_q    <= CK_OFF;
            oe_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            ddr_q   <= ddr_d;
            ck_q    <= ck_d;
            oe_q    <= oe_d;
            done_q  <= done_d;
        end
    end

    assign o_busy   = busy_s;
    assign o_ddr    = ddr_q;
    assign o_ck_ddr = ck_q;
    assign o_oe     = oe_q;
    assign o_done   = done_q;

endmodule

// File: tb/tb_oddr_serializer.sv
// Self-checking bench for oddr_serializer: three parameterisations driven from
// one initial block, checked against a beat-indexed reference model.
module tb_oddr_serializer;

    localparam int R = 4;

    logic clk = 1'b0;
    logic clk_en = 1'b0;
    logic rst = 1'b0;

    always #5 if (clk_en) clk = ~clk;

    // main instance: 4 lanes, RATIO 4, MSB first
    logic        stb;
    logic [31:0] data;
    logic        busy, oe, done;
    logic [7:0]  ddr;
    logic [1:0]  ck;

    // single lane, LSB first
    logic        stb_l;
    logic [7:0]  data_l;
    logic        busy_l, oe_l, done_l;
    logic [1:0]  ddr_l;
    logic [1:0]  ck_l;

    // two lanes, RATIO 1
    logic        stb_1;
    logic [3:0]  data_1;
    logic        busy_1, oe_1, done_1;
    logic [3:0]  ddr_1;
    logic [1:0]  ck_1;

    oddr_serializer #(.NLANES(4), .RATIO(4), .IDLE(1'b1), .MSB_FIRST(1)) u_dut (
        .i_clk(clk), .i_reset(rst), .i_stb(stb), .i_data(data),
        .o_busy(busy), .o_ddr(ddr), .o_ck_ddr(ck), .o_oe(oe), .o_done(done)
    );

    oddr_serializer #(.NLANES(1), .RATIO(4), .IDLE(1'b1), .MSB_FIRST(0)) u_lsb (
        .i_clk(clk), .i_reset(rst), .i_stb(stb_l), .i_data(data_l),
        .o_busy(busy_l), .o_ddr(ddr_l), .o_ck_ddr(ck_l), .o_oe(oe_l), .o_done(done_l)
    );

    oddr_serializer #(.NLANES(2), .RATIO(1), .IDLE(1'b1), .MSB_FIRST(1)) u_r1 (
        .i_clk(clk), .i_reset(rst), .i_stb(stb_1), .i_data(data_1),
        .o_busy(busy_1), .o_ddr(ddr_1), .o_ck_ddr(ck_1), .o_oe(oe_1), .o_done(done_1)
    );

    int n_cmp = 0;
    int n_err = 0;

    // reference model of the main instance: word in flight and beats still to show
    logic [31:0] m_word = 32'h0;
    int          m_rem = 0;

    // Pair of lane k at beat j, taken straight from the bit-order rules.
    function automatic logic [7:0] ref_ddr(input logic [31:0] w, input int nl, input int sw,
                                           input int j, input bit msb);
        logic [7:0] r;
        int b;
        r = 8'h00;
        for (int k = 0; k < nl; k++) begin
            b = k * sw;
            if (msb) begin
                r[2*k+1] = w[b+sw-1-2*j];
                r[2*k]   = w[b+sw-2-2*j];
            end else begin
                r[2*k+1] = w[b+2*j];
                r[2*k]   = w[b+2*j+1];
            end
        end
        return r;
    endfunction

    // Expected {busy, done, oe, ck, ddr} of the main instance.
    function automatic logic [12:0] exp_main(input logic [31:0] w, input int rem);
        if (rem > 0)
            return {rem > 1, rem == 1, 1'b1, 2'b10, ref_ddr(w, 4, 8, R - rem, 1'b1)};
        else
            return {1'b0, 1'b0, 1'b0, 2'b00, 8'hFF};
    endfunction

    // Advance the model across one rising edge with the given request.
    task automatic main_step(input logic s, input logic [31:0] w, output bit acc);
        acc = s && (m_rem <= 1);
        if (acc) begin
            m_word = w;
            m_rem  = R;
        end else if (m_rem > 0) begin
            m_rem = m_rem - 1;
        end
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        n_cmp++;
        if ({busy, done, oe, ck, ddr} !== {5'b00000, 8'hFF}) begin
            n_err++;
            $display("FAIL reset_main got %b want %b", {busy, done, oe, ck, ddr}, {5'b00000, 8'hFF});
        end
        n_cmp++;
        if ({busy_l, done_l, oe_l, ck_l, ddr_l} !== 7'b0000011) begin
            n_err++;
            $display("FAIL reset_lsb got %b want %b", {busy_l, done_l, oe_l, ck_l, ddr_l}, 7'b0000011);
        end
        n_cmp++;
        if ({busy_1, done_1, oe_1, ck_1, ddr_1} !== 9'b000001111) begin
            n_err++;
            $display("FAIL reset_r1 got %b want %b", {busy_1, done_1, oe_1, ck_1, ddr_1}, 9'b000001111);
        end
        clk_en = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({busy, done, oe, ck, ddr} !== {5'b00000, 8'hFF}) begin
            n_err++;
            $display("FAIL reset_held got %b want %b", {busy, done, oe, ck, ddr}, {5'b00000, 8'hFF});
        end
        rst = 1'b0;
        m_rem = 0;
    endtask

    task automatic test_single();
        logic [1:0] pr [5];
        logic [4:0] bz, dn, en;
        bit acc;
        pr = '{2'b10, 2'b11, 2'b01, 2'b00, 2'b11};
        bz = 5'b00111;
        dn = 5'b01000;
        en = 5'b01111;
        data = $urandom;
        data[7:0] = 8'hB4;
        stb = 1'b1;
        main_step(stb, data, acc);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({busy, done, oe, ddr[1:0]} !== {bz[i], dn[i], en[i], pr[i]}) begin
                n_err++;
                $display("FAIL single_lane0 beat %0d got %b want %b", i,
                         {busy, done, oe, ddr[1:0]}, {bz[i], dn[i], en[i], pr[i]});
            end
            n_cmp++;
            if ({busy, done, oe, ck, ddr} !== exp_main(m_word, m_rem)) begin
                n_err++;
                $display("FAIL single_model beat %0d got %b want %b", i,
                         {busy, done, oe, ck, ddr}, exp_main(m_word, m_rem));
            end
            stb = 1'b0;
            main_step(stb, data, acc);
        end
    endtask

    task automatic test_back_to_back();
        bit acc;
        logic oe_e, done_e;
        logic [7:0] ddr_e;
        stb = 1'b1;
        data = 32'hFFFF_FFFF;
        main_step(stb, data, acc);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            oe_e   = (i < 8);
            done_e = (i == 3) || (i == 7);
            ddr_e  = (i < 4 || i == 8) ? 8'hFF : 8'h00;
            n_cmp++;
            if ({oe, ck, done, ddr} !== {oe_e, oe_e ? 2'b10 : 2'b00, done_e, ddr_e}) begin
                n_err++;
                $display("FAIL b2b beat %0d got %b want %b", i, {oe, ck, done, ddr},
                         {oe_e, oe_e ? 2'b10 : 2'b00, done_e, ddr_e});
            end
            n_cmp++;
            if ({busy, done, oe, ck, ddr} !== exp_main(m_word, m_rem)) begin
                n_err++;
                $display("FAIL b2b_model beat %0d got %b want %b", i,
                         {busy, done, oe, ck, ddr}, exp_main(m_word, m_rem));
            end
            if (i < 4) begin
                stb  = 1'b1;
                data = 32'h0000_0000;
            end else begin
                stb = 1'b0;
            end
            main_step(stb, data, acc);
        end
    endtask

    task automatic test_lsb_first();
        logic [1:0] pr [5];
        logic [7:0] w, tmp;
        logic [1:0] p_e;
        logic [4:0] bz, dn, en;
        pr = '{2'b00, 2'b10, 2'b11, 2'b01, 2'b11};
        bz = 5'b00111;
        dn = 5'b01000;
        en = 5'b01111;
        for (int n = 0; n < 6; n++) begin
            w = (n == 0) ? 8'hB4 : 8'($urandom);
            stb_l  = 1'b1;
            data_l = w;
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                tmp = ref_ddr({24'h0, w}, 1, 8, (i < 4) ? i : 0, 1'b0);
                p_e = (i < 4) ? tmp[1:0] : 2'b11;
                n_cmp++;
                if ({busy_l, done_l, oe_l, ck_l, ddr_l} !==
                    {bz[i], dn[i], en[i], en[i] ? 2'b10 : 2'b00, p_e}) begin
                    n_err++;
                    $display("FAIL lsb word %0d beat %0d got %b want %b", n, i,
                             {busy_l, done_l, oe_l, ck_l, ddr_l},
                             {bz[i], dn[i], en[i], en[i] ? 2'b10 : 2'b00, p_e});
                end
                if (n == 0) begin
                    n_cmp++;
                    if (ddr_l !== pr[i]) begin
                        n_err++;
                        $display("FAIL lsb_b4 beat %0d got %b want %b", i, ddr_l, pr[i]);
                    end
                end
                stb_l  = 1'b0;
                data_l = 8'($urandom);
            end
        end
    endtask

    task automatic test_multilane();
        logic [7:0] de [5];
        bit acc;
        de = '{8'h39, 8'h39, 8'hC9, 8'hC9, 8'hFF};
        stb = 1'b1;
        data = 32'h0FF0_AA55;
        main_step(stb, data, acc);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if (ddr !== de[i]) begin
                n_err++;
                $display("FAIL multilane beat %0d got %h want %h", i, ddr, de[i]);
            end
            n_cmp++;
            if ({busy, done, oe, ck, ddr} !== exp_main(m_word, m_rem)) begin
                n_err++;
                $display("FAIL multilane_model beat %0d got %b want %b", i,
                         {busy, done, oe, ck, ddr}, exp_main(m_word, m_rem));
            end
            stb = 1'b0;
            main_step(stb, data, acc);
        end
    endtask

    task automatic test_random_stream();
        int sent, cyc;
        bit pend, acc;
        logic [31:0] pw;
        sent = 0;
        cyc = 0;
        pend = 1'b0;
        pw = 32'h0;
        while ((sent < 40 || m_rem > 0 || pend) && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            n_cmp++;
            if ({busy, done, oe, ck, ddr} !== exp_main(m_word, m_rem)) begin
                n_err++;
                $display("FAIL stream cycle %0d got %b want %b", cyc,
                         {busy, done, oe, ck, ddr}, exp_main(m_word, m_rem));
            end
            if (!pend && sent < 40 && $urandom_range(0, 2) != 0) begin
                pend = 1'b1;
                pw = $urandom;
            end
            stb  = pend;
            data = pend ? pw : $urandom;
            main_step(stb, data, acc);
            if (acc) begin
                pend = 1'b0;
                sent++;
            end
        end
        n_cmp++;
        if (sent != 40 || m_rem != 0) begin
            n_err++;
            $display("FAIL stream_budget sent %0d want 40 remaining %0d want 0", sent, m_rem);
        end
        @(negedge clk);
        stb = 1'b0;
        n_cmp++;
        if ({busy, done, oe, ck, ddr} !== exp_main(m_word, m_rem)) begin
            n_err++;
            $display("FAIL stream_tail got %b want %b", {busy, done, oe, ck, ddr},
                     exp_main(m_word, m_rem));
        end
        main_step(stb, data, acc);
    endtask

    task automatic test_ratio1();
        bit valid;
        logic [3:0] w;
        logic [7:0] tmp;
        logic [8:0] e;
        valid = 1'b0;
        w = 4'h0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            tmp = ref_ddr({28'h0, w}, 2, 2, 0, 1'b1);
            e = valid ? {1'b0, 1'b1, 1'b1, 2'b10, tmp[3:0]} : 9'b000001111;
            n_cmp++;
            if ({busy_1, done_1, oe_1, ck_1, ddr_1} !== e) begin
                n_err++;
                $display("FAIL ratio1 cycle %0d got %b want %b", i,
                         {busy_1, done_1, oe_1, ck_1, ddr_1}, e);
            end
            stb_1  = (i < 58) && ($urandom_range(0, 3) != 0);
            data_1 = 4'($urandom);
            valid  = stb_1;
            w      = data_1;
        end
        stb_1 = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit acc;
        stb = 1'b1;
        data = $urandom;
        main_step(stb, data, acc);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({busy, done, oe, ck, ddr} !== exp_main(m_word, m_rem)) begin
                n_err++;
                $display("FAIL pre_abort beat %0d got %b want %b", i,
                         {busy, done, oe, ck, ddr}, exp_main(m_word, m_rem));
            end
            stb = 1'b0;
            main_step(stb, data, acc);
        end
        #2 rst = 1'b1;
        m_rem = 0;
        #1;
        n_cmp++;
        if ({busy, done, oe, ck, ddr} !== {5'b00000, 8'hFF}) begin
            n_err++;
            $display("FAIL abort_async got %b want %b", {busy, done, oe, ck, ddr}, {5'b00000, 8'hFF});
        end
        @(negedge clk);
        n_cmp++;
        if ({busy, done, oe, ck, ddr} !== {5'b00000, 8'hFF}) begin
            n_err++;
            $display("FAIL abort_held got %b want %b", {busy, done, oe, ck, ddr}, {5'b00000, 8'hFF});
        end
        rst = 1'b0;
        stb = 1'b1;
        data = $urandom;
        main_step(stb, data, acc);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({busy, done, oe, ck, ddr} !== exp_main(m_word, m_rem)) begin
                n_err++;
                $display("FAIL post_abort beat %0d got %b want %b", i,
                         {busy, done, oe, ck, ddr}, exp_main(m_word, m_rem));
            end
            stb = 1'b0;
            main_step(stb, data, acc);
        end
    endtask

    initial begin
        stb = 1'b0;
        data = 32'h0;
        stb_l = 1'b0;
        data_l = 8'h0;
        stb_1 = 1'b0;
        data_1 = 4'h0;
        test_reset();
        test_single();
        test_back_to_back();
        test_lsb_first();
        test_multilane();
        test_random_stream();
        test_ratio1();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
